// File: rtl/lsu_data_bus_master.sv
// LSU-side data bus initiator: turns one byte/half/word load or store into a single
// word-aligned bus transaction and returns the lane-extracted, extended load result.
module lsu_data_bus_master #(
  parameter int BUS_AW  = 32,
  parameter int BUS_DW  = 32,
  parameter int BUS_DBW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lsu_valid_i,
  output logic               lsu_ready_o,
  input  logic               lsu_we_i,
  input  logic [1:0]         lsu_size_i,
  input  logic               lsu_sign_ext_i,
  input  logic [BUS_AW-1:0]  lsu_addr_i,
  input  logic [BUS_DW-1:0]  lsu_wdata_i,
  output logic               lsu_resp_valid_o,
  output logic [BUS_DW-1:0]  lsu_rdata_o,
  output logic               lsu_err_o,
  output logic               data_req_o,
  output logic [BUS_AW-1:0]  data_addr_o,
  output logic               data_we_o,
  output logic [BUS_DBW-1:0] data_be_o,
  output logic [BUS_DW-1:0]  data_wdata_o,
  input  logic               data_gnt_i,
  input  logic               data_rvalid_i,
  input  logic [BUS_DW-1:0]  data_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT_RV = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_we;
  logic              r_sign;
  logic [1:0]        r_size;
  logic [BUS_AW-1:0] r_addr;
  logic [BUS_DW-1:0] r_wdata;

  logic              r_resp_valid;
  logic              r_err;
  logic [BUS_DW-1:0] r_rdata;

  logic              w_capture;
  logic              w_resp_ok;
  logic              w_resp_err;
  logic              w_cmd_bad;
  logic [1:0]        w_off;
  logic [4:0]        w_shamt;
  logic [BUS_DW-1:0] w_shifted;
  logic [BUS_DW-1:0] w_load;

  assign w_cmd_bad = (lsu_size_i == 2'b11)
                   | ((lsu_size_i == 2'b01) & lsu_addr_i[0])
                   | ((lsu_size_i == 2'b10) & (|lsu_addr_i[1:0]));

  assign w_off   = r_addr[1:0];
  assign w_shamt = {w_off, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_resp_ok   = 1'b0;
    w_resp_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lsu_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = w_cmd_bad ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (data_gnt_i) w_state_nxt = S_WAIT_RV;
      end
      S_WAIT_RV: begin
        if (data_rvalid_i) begin
          w_resp_ok   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        w_resp_err  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_capture) begin
      r_we    <= lsu_we_i;
      r_sign  <= lsu_sign_ext_i;
      r_size  <= lsu_size_i;
      r_addr  <= lsu_addr_i;
      r_wdata <= lsu_wdata_i;
    end
  end

  // Bus fields are only driven while requesting; everything else reads as zero.
  always_comb begin
    data_req_o   = 1'b0;
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (r_state == S_REQ) begin
      data_req_o   = 1'b1;
      data_addr_o  = {r_addr[BUS_AW-1:2], 2'b00};
      data_we_o    = r_we;
      data_wdata_o = r_wdata << w_shamt;
      case (r_size)
        2'b00:   data_be_o = BUS_DBW'(4'b0001) << w_off;
        2'b01:   data_be_o = BUS_DBW'(4'b0011) << w_off;
        default: data_be_o = '1;
      endcase
    end
  end

  assign w_shifted = data_rdata_i >> w_shamt;

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{(BUS_DW-8){r_sign & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = {{(BUS_DW-16){r_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_resp_valid <= w_resp_ok | w_resp_err;
      r_err        <= w_resp_err;
      r_rdata      <= (w_resp_ok && !r_we) ? w_load : '0;
    end
  end

  assign lsu_ready_o      = (r_state == S_IDLE);
  assign lsu_resp_valid_o = r_resp_valid;
  assign lsu_err_o        = r_err;
  assign lsu_rdata_o      = r_rdata;

endmodule

// File: tb/tb_lsu_data_bus_master.sv
// Directed bench for lsu_data_bus_master: inputs change and outputs are checked on the
// falling edge, with hand-computed expectations for each step.
module tb_lsu_data_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic        lsu_we_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_sign_ext_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_resp_valid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  int n_total  = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  lsu_data_bus_master dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_valid_i      (lsu_valid_i),
    .lsu_ready_o      (lsu_ready_o),
    .lsu_we_i         (lsu_we_i),
    .lsu_size_i       (lsu_size_i),
    .lsu_sign_ext_i   (lsu_sign_ext_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_rdata_o      (lsu_rdata_o),
    .lsu_err_o        (lsu_err_o),
    .data_req_o       (data_req_o),
    .data_addr_o      (data_addr_o),
    .data_we_o        (data_we_o),
    .data_be_o        (data_be_o),
    .data_wdata_o     (data_wdata_o),
    .data_gnt_i       (data_gnt_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_rdata_i     (data_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic cmd(input logic we, input logic [1:0] size, input logic sign,
                     input logic [31:0] addr, input logic [31:0] wdata);
    lsu_valid_i    = 1'b1;
    lsu_we_i       = we;
    lsu_size_i     = size;
    lsu_sign_ext_i = sign;
    lsu_addr_i     = addr;
    lsu_wdata_i    = wdata;
  endtask

  // Load with immediate grant and rvalid one cycle later; returns in the response cycle.
  task automatic do_load(input string tag, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] rd, input logic [31:0] exp);
    cmd(1'b0, size, sign, addr, 32'h0);
    cyc();
    lsu_valid_i = 1'b0;
    chk({tag, "_req"}, {31'b0, data_req_o}, 32'd1);
    chk({tag, "_be"}, {28'b0, data_be_o}, {28'b0, be});
    data_gnt_i = 1'b1;
    cyc();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = rd;
    cyc();
    data_rvalid_i = 1'b0;
    chk({tag, "_resp"}, {31'b0, lsu_resp_valid_o}, 32'd1);
    chk({tag, "_rdata"}, lsu_rdata_o, exp);
    chk({tag, "_err"}, {31'b0, lsu_err_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    lsu_valid_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_sign_ext_i = 1'b0;
    lsu_addr_i = '0; lsu_wdata_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    cyc();
    chk("rst_ready", {31'b0, lsu_ready_o}, 32'd1);
    chk("rst_req", {31'b0, data_req_o}, 32'd0);
    chk("rst_resp", {31'b0, lsu_resp_valid_o}, 32'd0);
    chk("rst_addr", data_addr_o, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // word load 0x1000
    cmd(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0);
    cyc();
    lsu_valid_i = 1'b0;
    chk("wl_req", {31'b0, data_req_o}, 32'd1);
    chk("wl_ready", {31'b0, lsu_ready_o}, 32'd0);
    chk("wl_addr", data_addr_o, 32'h0000_1000);
    chk("wl_be", {28'b0, data_be_o}, 32'hF);
    chk("wl_we", {31'b0, data_we_o}, 32'd0);
    data_gnt_i = 1'b1;
    cyc();
    data_gnt_i = 1'b0;
    chk("wl_req_drop", {31'b0, data_req_o}, 32'd0);
    chk("wl_addr_zero", data_addr_o, 32'h0);
    chk("wl_noresp", {31'b0, lsu_resp_valid_o}, 32'd0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hDEAD_BEEF;
    cyc();
    data_rvalid_i = 1'b0;
    chk("wl_resp", {31'b0, lsu_resp_valid_o}, 32'd1);
    chk("wl_rdata", lsu_rdata_o, 32'hDEAD_BEEF);
    chk("wl_err", {31'b0, lsu_err_o}, 32'd0);
    chk("wl_ready_back", {31'b0, lsu_ready_o}, 32'd1);
    cyc();
    chk("wl_pulse_end", {31'b0, lsu_resp_valid_o}, 32'd0);
    chk("wl_rdata_clr", lsu_rdata_o, 32'h0);

    // byte store 0x2003 with three stall cycles
    cmd(1'b1, 2'b00, 1'b0, 32'h0000_2003, 32'h0000_00A5);
    cyc();
    lsu_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bs_req", {31'b0, data_req_o}, 32'd1);
      chk("bs_addr", data_addr_o, 32'h0000_2000);
      chk("bs_be", {28'b0, data_be_o}, 32'h8);
      chk("bs_wdata", data_wdata_o, 32'hA500_0000);
      chk("bs_we", {31'b0, data_we_o}, 32'd1);
      if (i == 3) data_gnt_i = 1'b1;
      cyc();
    end
    data_gnt_i = 1'b0;
    chk("bs_req_drop", {31'b0, data_req_o}, 32'd0);
    chk("bs_wdata_zero", data_wdata_o, 32'h0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h1234_5678;
    cyc();
    data_rvalid_i = 1'b0;
    chk("bs_resp", {31'b0, lsu_resp_valid_o}, 32'd1);
    chk("bs_rdata", lsu_rdata_o, 32'h0);
    chk("bs_err", {31'b0, lsu_err_o}, 32'd0);
    cyc();
    chk("bs_single", {31'b0, lsu_resp_valid_o}, 32'd0);

    // half and byte loads with extension
    do_load("hl_sx", 2'b01, 1'b1, 32'h0000_3002, 4'b1100, 32'h8001_1234, 32'hFFFF_8001);
    cyc();
    do_load("hl_zx", 2'b01, 1'b0, 32'h0000_3002, 4'b1100, 32'h8001_1234, 32'h0000_8001);
    cyc();
    do_load("bl", 2'b00, 1'b1, 32'h0000_3001, 4'b0010, 32'h0000_7F00, 32'h0000_007F);
    cyc();
    do_load("bl_sx", 2'b00, 1'b1, 32'h0000_3000, 4'b0001, 32'h1234_5680, 32'hFFFF_FF80);
    cyc();

    // misaligned word and reserved size
    cmd(1'b0, 2'b10, 1'b0, 32'h0000_4001, 32'h0);
    cyc();
    lsu_valid_i = 1'b0;
    chk("mis_noreq", {31'b0, data_req_o}, 32'd0);
    chk("mis_noresp", {31'b0, lsu_resp_valid_o}, 32'd0);
    cyc();
    chk("mis_resp", {31'b0, lsu_resp_valid_o}, 32'd1);
    chk("mis_err", {31'b0, lsu_err_o}, 32'd1);
    chk("mis_noreq2", {31'b0, data_req_o}, 32'd0);
    chk("mis_rdata", lsu_rdata_o, 32'h0);
    cyc();
    chk("mis_err_clr", {31'b0, lsu_err_o}, 32'd0);
    cmd(1'b1, 2'b11, 1'b0, 32'h0000_4000, 32'h55);
    cyc();
    lsu_valid_i = 1'b0;
    chk("rsv_noreq", {31'b0, data_req_o}, 32'd0);
    cyc();
    chk("rsv_resp", {31'b0, lsu_resp_valid_o}, 32'd1);
    chk("rsv_err", {31'b0, lsu_err_o}, 32'd1);
    cyc();
    cmd(1'b0, 2'b01, 1'b0, 32'h0000_4003, 32'h0);
    cyc();
    lsu_valid_i = 1'b0;
    chk("mish_noreq", {31'b0, data_req_o}, 32'd0);
    cyc();
    chk("mish_err", {31'b0, lsu_err_o}, 32'd1);
    cyc();

    // back-to-back, spurious rvalid in REQ and rvalid coinciding with gnt
    do_load("b2b1", 2'b10, 1'b0, 32'h0000_5000, 4'hF, 32'hCAFE_F00D, 32'hCAFE_F00D);
    chk("b2b_ready", {31'b0, lsu_ready_o}, 32'd1);
    cmd(1'b0, 2'b01, 1'b0, 32'h0000_5002, 32'h0);
    cyc();
    lsu_valid_i = 1'b0;
    chk("b2b_req", {31'b0, data_req_o}, 32'd1);
    chk("b2b_be", {28'b0, data_be_o}, 32'hC);
    chk("b2b_pulse_end", {31'b0, lsu_resp_valid_o}, 32'd0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h1111_1111;
    cyc();
    data_rvalid_i = 1'b0;
    chk("spur_req", {31'b0, data_req_o}, 32'd1);
    chk("spur_noresp", {31'b0, lsu_resp_valid_o}, 32'd0);
    data_gnt_i    = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hAAAA_0000;
    cyc();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    chk("gntrv_req", {31'b0, data_req_o}, 32'd0);
    chk("gntrv_noresp", {31'b0, lsu_resp_valid_o}, 32'd0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hBEEF_0000;
    cyc();
    data_rvalid_i = 1'b0;
    chk("b2b2_resp", {31'b0, lsu_resp_valid_o}, 32'd1);
    chk("b2b2_rdata", lsu_rdata_o, 32'h0000_BEEF);
    cyc();
    chk("b2b2_single", {31'b0, lsu_resp_valid_o}, 32'd0);

    // asynchronous reset while waiting for rvalid
    cmd(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
    cyc();
    lsu_valid_i = 1'b0;
    data_gnt_i  = 1'b1;
    cyc();
    data_gnt_i = 1'b0;
    chk("rstw_busy", {31'b0, lsu_ready_o}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstw_ready", {31'b0, lsu_ready_o}, 32'd1);
    chk("rstw_req", {31'b0, data_req_o}, 32'd0);
    chk("rstw_resp", {31'b0, lsu_resp_valid_o}, 32'd0);
    cyc();
    rst = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h0000_1234;
    cyc();
    data_rvalid_i = 1'b0;
    chk("late_rv_noresp", {31'b0, lsu_resp_valid_o}, 32'd0);
    chk("late_rv_ready", {31'b0, lsu_ready_o}, 32'd1);
    cyc();
    chk("late_rv_noresp2", {31'b0, lsu_resp_valid_o}, 32'd0);
    chk("late_rv_rdata", lsu_rdata_o, 32'h0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
